// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard scoreboard slice.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
package hazard_pkg;

   localparam int NUM_SRC_DEF         = 2;
   localparam int NUM_REGS_DEF        = 32;
   localparam int REG_AW_DEF          = 5;
   localparam int MAX_OUTSTANDING_DEF = 4;

   // E-stage operand mux select
   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwdSel_e;

   // Width of a counter that must hold values 0..maxOut inclusive
   function automatic int cntWidth(input int maxOut);
      return $clog2(maxOut + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard unit signal bundle. The master side is the core
// pipeline (drives stage indices and enables), the slave side is the
// hazard scoreboard. With HAZARD_PERF_EN defined the perf counters are
// carried here as well.
interface hazard_scoreboard_if import hazard_pkg::*; #(
   parameter int NUM_SRC         = NUM_SRC_DEF,
   parameter int NUM_REGS        = NUM_REGS_DEF,
   parameter int REG_AW          = REG_AW_DEF,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
);
   localparam int CNT_W = cntWidth(MAX_OUTSTANDING);

   // D stage
   logic [NUM_SRC*REG_AW-1:0] RsD;
   logic [REG_AW-1:0]         RdD;
   logic                      RegWriteD;
   logic                      LongOpD;
   // E stage
   logic [NUM_SRC*REG_AW-1:0] RsE;
   logic [REG_AW-1:0]         RdE;
   logic                      PCSrcE;
   logic                      ResultSrcEb0;
   logic                      LongIssueE;
   // M / W stages
   logic [REG_AW-1:0]         RdM;
   logic [REG_AW-1:0]         RdW;
   logic                      RegWriteM;
   logic                      RegWriteW;
   // long-latency unit retirement
   logic                      CmplValid;
   logic [REG_AW-1:0]         CmplRd;
   // control back to the pipeline
   logic                      StallF;
   logic                      StallD;
   logic                      FlushD;
   logic                      FlushE;
   logic [NUM_SRC*2-1:0]      ForwardE;
   logic [NUM_REGS-1:0]       BusyRegs;
   logic [CNT_W-1:0]          OutstandingCnt;
`ifdef HAZARD_PERF_EN
   logic [31:0]               PerfLwStall;
   logic [31:0]               PerfSbStall;
   logic [31:0]               PerfFlush;
`endif

   modport master (
`ifdef HAZARD_PERF_EN
      input  PerfLwStall, PerfSbStall, PerfFlush,
`endif
      output RsD, RdD, RegWriteD, LongOpD,
      output RsE, RdE, PCSrcE, ResultSrcEb0, LongIssueE,
      output RdM, RdW, RegWriteM, RegWriteW,
      output CmplValid, CmplRd,
      input  StallF, StallD, FlushD, FlushE, ForwardE, BusyRegs, OutstandingCnt
   );

   modport slave (
`ifdef HAZARD_PERF_EN
      output PerfLwStall, PerfSbStall, PerfFlush,
`endif
      input  RsD, RdD, RegWriteD, LongOpD,
      input  RsE, RdE, PCSrcE, ResultSrcEb0, LongIssueE,
      input  RdM, RdW, RegWriteM, RegWriteW,
      input  CmplValid, CmplRd,
      output StallF, StallD, FlushD, FlushE, ForwardE, BusyRegs, OutstandingCnt
   );

endinterface

// File: rtl/hazard_sb_regs.sv
// Registered scoreboard state: one busy bit per architectural register
// plus the count of long ops in flight. A same-cycle issue and
// completion to one register leaves it busy (the new op is younger).
// x0 is never marked busy, but an x0-targeted long op still occupies
// a slot in the outstanding count.
module hazard_sb_regs import hazard_pkg::*; #(
   parameter int NUM_REGS        = NUM_REGS_DEF,
   parameter int REG_AW          = REG_AW_DEF,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
   localparam int CNT_W          = cntWidth(MAX_OUTSTANDING)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issueValid,
   input  logic [REG_AW-1:0]   issueRd,
   input  logic                cmplValid,
   input  logic [REG_AW-1:0]   cmplRd,
   output logic [NUM_REGS-1:0] busyRegs,
   output logic [CNT_W-1:0]    outstandingCnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [NUM_REGS-1:0] busyNext;
   logic [CNT_W-1:0]    cntNext;

   // Next busy vector: clear on completion first so that a same-cycle issue wins
   always_comb begin
      busyNext = busyRegs;
      if (cmplValid) begin
         busyNext[cmplRd] = 1'b0;
      end
      if (issueValid && (issueRd != '0)) begin
         busyNext[issueRd] = 1'b1;
      end
      busyNext[0] = 1'b0;
   end

   // Next outstanding count: saturates at both ends instead of wrapping
   always_comb begin
      cntNext = outstandingCnt;
      if (issueValid && !cmplValid && (outstandingCnt != CNT_MAX)) begin
         cntNext = outstandingCnt + CNT_W'(1);
      end else if (cmplValid && !issueValid && (outstandingCnt != '0)) begin
         cntNext = outstandingCnt - CNT_W'(1);
      end
   end

   // State registers, cleared asynchronously together with the long unit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busyRegs       <= '0;
         outstandingCnt <= '0;
      end else begin
         busyRegs       <= busyNext;
         outstandingCnt <= cntNext;
      end
   end

   // An issue into a full window means the stall logic was bypassed
   aOverflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(issueValid && !cmplValid && (outstandingCnt == CNT_MAX)))
      else $error("hazard_sb_regs: long-op issue with counter at maximum");

   // A completion with nothing in flight means the long unit lost track
   aUnderflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(cmplValid && !issueValid && (outstandingCnt == '0)))
      else $error("hazard_sb_regs: long-op completion with counter at zero");

   // x0 must never appear busy
   aX0Clear : assert property (@(posedge clk) disable iff (!rst_n)
      busyRegs[0] == 1'b0)
      else $error("hazard_sb_regs: busy bit set on x0");

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core: M/W-to-E forwarding, load-use stall,
// branch flush, and a scoreboard that stalls D on registers still owned
// by in-flight long-latency ops (MUL/DIV) retiring out-of-band.
// Define HAZARD_PERF_EN to add saturating stall/flush perf counters.
module hazard_scoreboard import hazard_pkg::*; #(
   parameter int NUM_SRC         = NUM_SRC_DEF,
   parameter int NUM_REGS        = NUM_REGS_DEF,
   parameter int REG_AW          = REG_AW_DEF,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hazard_scoreboard_if.slave   hz
);

   localparam int               CNT_W   = cntWidth(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [NUM_REGS-1:0]  busyRegs;
   logic [CNT_W-1:0]     outstandingCnt;
   logic [NUM_SRC*2-1:0] forwardSel;
   logic [REG_AW-1:0]    rsE;
   logic [REG_AW-1:0]    rsD;
   fwdSel_e              sel;
   logic                 lwHit;
   logic                 rawHit;
   logic                 wawHit;
   logic                 structHit;
   logic                 lwStall;
   logic                 sbStall;

   hazard_sb_regs #(
      .NUM_REGS        (NUM_REGS),
      .REG_AW          (REG_AW),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) uSbRegs (
      .clk            (clk),
      .rst_n          (rst_n),
      .issueValid     (hz.LongIssueE),
      .issueRd        (hz.RdE),
      .cmplValid      (hz.CmplValid),
      .cmplRd         (hz.CmplRd),
      .busyRegs       (busyRegs),
      .outstandingCnt (outstandingCnt)
   );

   // Per-slot forward select; M is younger than W so it takes priority
   always_comb begin
      forwardSel = '0;
      rsE        = '0;
      sel        = FWD_RF;
      for (int i = 0; i < NUM_SRC; i++) begin
         rsE = hz.RsE[i*REG_AW +: REG_AW];
         if (rsE == '0) begin
            sel = FWD_RF;
         end else if (hz.RegWriteM && (rsE == hz.RdM)) begin
            sel = FWD_M;
         end else if (hz.RegWriteW && (rsE == hz.RdW)) begin
            sel = FWD_W;
         end else begin
            sel = FWD_RF;
         end
         forwardSel[i*2 +: 2] = sel;
      end
   end

   // D-stage stall sources; load-use deliberately includes x0 like the old unit
   always_comb begin
      lwHit  = 1'b0;
      rawHit = 1'b0;
      rsD    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         rsD = hz.RsD[i*REG_AW +: REG_AW];
         if (rsD == hz.RdE) begin
            lwHit = 1'b1;
         end
         if ((rsD != '0) && busyRegs[rsD]) begin
            rawHit = 1'b1;
         end
      end
      wawHit    = hz.RegWriteD && (hz.RdD != '0) && busyRegs[hz.RdD];
      structHit = hz.LongOpD && (outstandingCnt == CNT_MAX);
      lwStall   = hz.ResultSrcEb0 && lwHit;
      sbStall   = rawHit || wawHit || structHit;
   end

   assign hz.StallF         = lwStall | sbStall;
   assign hz.StallD         = lwStall | sbStall;
   assign hz.FlushD         = hz.PCSrcE;
   assign hz.FlushE         = lwStall | sbStall | hz.PCSrcE;
   assign hz.ForwardE       = forwardSel;
   assign hz.BusyRegs       = busyRegs;
   assign hz.OutstandingCnt = outstandingCnt;

`ifdef HAZARD_PERF_EN
   logic [31:0] perfLwStall;
   logic [31:0] perfSbStall;
   logic [31:0] perfFlush;

   function automatic logic [31:0] satInc(input logic [31:0] value, input logic en);
      if (en && (value != 32'hFFFF_FFFF)) begin
         return value + 32'd1;
      end
      return value;
   endfunction

   // Event counters; a scoreboard stall hidden behind a load-use stall is not counted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perfLwStall <= '0;
         perfSbStall <= '0;
         perfFlush   <= '0;
      end else begin
         perfLwStall <= satInc(perfLwStall, lwStall);
         perfSbStall <= satInc(perfSbStall, sbStall && !lwStall);
         perfFlush   <= satInc(perfFlush, hz.PCSrcE);
      end
   end

   assign hz.PerfLwStall = perfLwStall;
   assign hz.PerfSbStall = perfSbStall;
   assign hz.PerfFlush   = perfFlush;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed cases followed by random traffic.
// Each driven cycle pushes its predicted outputs into a queue; a monitor
// on the falling edge pops and compares against what the DUT shows.
module tb_hazard_scoreboard;
   localparam int NSRC = 3;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int MAXO = 4;
   localparam int CW   = $clog2(MAXO + 1);

   typedef struct {
      logic              rstN;
      logic [NSRC*AW-1:0] RsD;
      logic [AW-1:0]     RdD;
      logic              RegWriteD;
      logic              LongOpD;
      logic [NSRC*AW-1:0] RsE;
      logic [AW-1:0]     RdE;
      logic [AW-1:0]     RdM;
      logic [AW-1:0]     RdW;
      logic              PCSrcE;
      logic              ResultSrcEb0;
      logic              RegWriteM;
      logic              RegWriteW;
      logic              LongIssueE;
      logic              CmplValid;
      logic [AW-1:0]     CmplRd;
   } stim_t;

   typedef struct {
      int               ph;
      logic [3:0]       ctl;   // {StallF, StallD, FlushD, FlushE}
      logic [2*NSRC-1:0] fwd;
      logic [NREG-1:0]  busy;
      logic [CW-1:0]    cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.NUM_SRC(NSRC), .NUM_REGS(NREG), .REG_AW(AW), .MAX_OUTSTANDING(MAXO)) hzIf ();

   hazard_scoreboard #(.NUM_SRC(NSRC), .NUM_REGS(NREG), .REG_AW(AW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hzIf)
   );

   int   nTests = 0;
   int   nFail  = 0;
   exp_t expQ[$];

   // reference state: which registers are marked busy, and the list of long ops in flight
   bit   mBusy[NREG];
   int   pend[$];

   task automatic chk(input int ph, input string name, input logic [63:0] got, input logic [63:0] want);
      nTests++;
      if (got !== want) begin
         nFail++;
         $display("FAIL %s phase%0d: got %h want %h", name, ph, got, want);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      s.rstN = 1'b1;
      return s;
   endfunction

   function automatic void modelClear();
      foreach (mBusy[r]) mBusy[r] = 1'b0;
      pend.delete();
   endfunction

   function automatic void modelStep(input stim_t s);
      if (s.CmplValid) begin
         for (int k = 0; k < pend.size(); k++) begin
            if (pend[k] == int'(s.CmplRd)) begin
               pend.delete(k);
               break;
            end
         end
         mBusy[s.CmplRd] = 1'b0;
      end
      if (s.LongIssueE) begin
         pend.push_back(int'(s.RdE));
         if (s.RdE != 0) mBusy[s.RdE] = 1'b1;
      end
   endfunction

   function automatic exp_t predict(input stim_t s, input int ph);
      exp_t e;
      logic [AW-1:0] r;
      bit lw, sb, stall;
      e.ph  = ph;
      e.fwd = '0;
      lw = 0;
      sb = 0;
      for (int i = 0; i < NSRC; i++) begin
         r = s.RsE[i*AW +: AW];
         if (r != 0 && s.RegWriteM && r == s.RdM)      e.fwd[i*2 +: 2] = 2'b10;
         else if (r != 0 && s.RegWriteW && r == s.RdW) e.fwd[i*2 +: 2] = 2'b01;
         r = s.RsD[i*AW +: AW];
         if (s.ResultSrcEb0 && r == s.RdE) lw = 1;
         if (r != 0 && mBusy[r]) sb = 1;
      end
      if (s.RegWriteD && s.RdD != 0 && mBusy[s.RdD]) sb = 1;
      if (s.LongOpD && pend.size() == MAXO) sb = 1;
      stall = lw || sb;
      e.ctl = {stall, stall, s.PCSrcE, stall || s.PCSrcE};
      for (int k = 0; k < NREG; k++) e.busy[k] = mBusy[k];
      e.cnt = CW'(pend.size());
      return e;
   endfunction

   task automatic applyCycle(input stim_t s, input int ph);
      hzIf.RsD          = s.RsD;
      hzIf.RdD          = s.RdD;
      hzIf.RegWriteD    = s.RegWriteD;
      hzIf.LongOpD      = s.LongOpD;
      hzIf.RsE          = s.RsE;
      hzIf.RdE          = s.RdE;
      hzIf.RdM          = s.RdM;
      hzIf.RdW          = s.RdW;
      hzIf.PCSrcE       = s.PCSrcE;
      hzIf.ResultSrcEb0 = s.ResultSrcEb0;
      hzIf.RegWriteM    = s.RegWriteM;
      hzIf.RegWriteW    = s.RegWriteW;
      hzIf.LongIssueE   = s.LongIssueE;
      hzIf.CmplValid    = s.CmplValid;
      hzIf.CmplRd       = s.CmplRd;
      rst_n             = s.rstN;
      if (!s.rstN) modelClear();
      expQ.push_back(predict(s, ph));
      @(posedge clk);
      if (!s.rstN) modelClear();
      else modelStep(s);
      #1;
   endtask

   task automatic issue(input int rd, input int ph);
      stim_t s;
      s = idle();
      s.LongIssueE = 1'b1;
      s.RdE = AW'(rd);
      applyCycle(s, ph);
   endtask

   task automatic complete(input int rd, input int ph);
      stim_t s;
      s = idle();
      s.CmplValid = 1'b1;
      s.CmplRd = AW'(rd);
      applyCycle(s, ph);
   endtask

   task automatic randCycle(input int ph);
      stim_t s;
      s = idle();
      for (int i = 0; i < NSRC; i++) begin
         s.RsD[i*AW +: AW] = AW'($urandom_range(0, 7));
         s.RsE[i*AW +: AW] = AW'($urandom_range(0, 7));
      end
      s.RdD          = AW'($urandom_range(0, 7));
      s.RdE          = AW'($urandom_range(0, 7));
      s.RdM          = AW'($urandom_range(0, 7));
      s.RdW          = AW'($urandom_range(0, 7));
      s.RegWriteD    = 1'($urandom_range(0, 1));
      s.LongOpD      = 1'($urandom_range(0, 1));
      s.PCSrcE       = ($urandom_range(0, 5) == 0);
      s.ResultSrcEb0 = ($urandom_range(0, 3) == 0);
      s.RegWriteM    = 1'($urandom_range(0, 1));
      s.RegWriteW    = 1'($urandom_range(0, 1));
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
         s.CmplValid = 1'b1;
         s.CmplRd    = AW'(pend[$urandom_range(0, pend.size() - 1)]);
      end
      if ($urandom_range(0, 2) == 0 && (pend.size() < MAXO || s.CmplValid)) begin
         s.LongIssueE = 1'b1;
      end
      applyCycle(s, ph);
   endtask

   // Monitor: compare DUT outputs with the oldest prediction, away from the rising edge
   always @(negedge clk) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         chk(e.ph, "ctl", 64'({hzIf.StallF, hzIf.StallD, hzIf.FlushD, hzIf.FlushE}), 64'(e.ctl));
         chk(e.ph, "fwd", 64'(hzIf.ForwardE), 64'(e.fwd));
         chk(e.ph, "busy", 64'(hzIf.BusyRegs), 64'(e.busy));
         chk(e.ph, "cnt", 64'(hzIf.OutstandingCnt), 64'(e.cnt));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s;
      modelClear();
      hzIf.RsD = '0; hzIf.RdD = '0; hzIf.RegWriteD = 0; hzIf.LongOpD = 0;
      hzIf.RsE = '0; hzIf.RdE = '0; hzIf.RdM = '0; hzIf.RdW = '0;
      hzIf.PCSrcE = 0; hzIf.ResultSrcEb0 = 0; hzIf.RegWriteM = 0; hzIf.RegWriteW = 0;
      hzIf.LongIssueE = 0; hzIf.CmplValid = 0; hzIf.CmplRd = '0;
      @(posedge clk);
      #1;

      // phase 0: reset state
      s = idle(); s.rstN = 1'b0;
      applyCycle(s, 0);
      applyCycle(s, 0);

      // phase 1: forwarding priority M over W, then W, then x0
      s = idle();
      s.RsE[0 +: AW] = 5; s.RdM = 5; s.RegWriteM = 1; s.RdW = 5; s.RegWriteW = 1;
      applyCycle(s, 1);
      s.RegWriteM = 0;
      applyCycle(s, 1);
      s.RsE[0 +: AW] = 0;
      applyCycle(s, 1);

      // phase 2: load-use on slot 1, then non-matching destination
      s = idle();
      s.ResultSrcEb0 = 1; s.RdE = 7; s.RsD[AW +: AW] = 7;
      applyCycle(s, 2);
      s.RdE = 8;
      applyCycle(s, 2);

      // phase 3: long RAW on x9 released one cycle after completion
      issue(9, 3);
      s = idle(); s.RsD[0 +: AW] = 9;
      applyCycle(s, 3);
      s.CmplValid = 1; s.CmplRd = 9;
      applyCycle(s, 3);
      s.CmplValid = 0;
      applyCycle(s, 3);

      // phase 4: same-cycle issue and completion on x4
      issue(4, 4);
      s = idle(); s.LongIssueE = 1; s.RdE = 4; s.CmplValid = 1; s.CmplRd = 4;
      s.RegWriteD = 1; s.RdD = 4;
      applyCycle(s, 4);
      s = idle(); s.RegWriteD = 1; s.RdD = 4;
      applyCycle(s, 4);
      complete(4, 4);

      // phase 5: structural stall with four long ops in flight
      for (int r = 1; r <= 4; r++) issue(r, 5);
      s = idle(); s.LongOpD = 1;
      applyCycle(s, 5);
      s.CmplValid = 1; s.CmplRd = 1;
      applyCycle(s, 5);
      s.CmplValid = 0;
      applyCycle(s, 5);
      for (int r = 2; r <= 4; r++) complete(r, 5);

      // phase 6: long op to x0 counts but never marks busy
      issue(0, 6);
      s = idle(); s.RsD[0 +: AW] = 0; s.RegWriteD = 1; s.RdD = 0;
      applyCycle(s, 6);
      complete(0, 6);

      // phase 7: random traffic
      for (int n = 0; n < 1500; n++) randCycle(7);

      // phase 8: reset while long ops are in flight, then resume
      if (pend.size() < MAXO) issue(12, 8);
      if (pend.size() < MAXO) issue(13, 8);
      s = idle(); s.rstN = 1'b0; s.LongIssueE = 1; s.RdE = 3; s.RsD[0 +: AW] = 12;
      applyCycle(s, 8);
      s = idle(); s.RsD[0 +: AW] = 12;
      applyCycle(s, 8);
      for (int n = 0; n < 200; n++) randCycle(9);

      @(negedge clk);
      #1;
      chk(99, "drain", 64'(expQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard unit for the 5-stage core.
- Keeps M/W-to-E forwarding, load-use stall and branch flush.
- Generalised to NUM_SRC source operands and NUM_REGS registers.
- Adds a registered scoreboard plus an outstanding-op counter, so multi-cycle long-latency ops (MUL/DIV) issued from E can retire out-of-band.

Parameters:
- NUM_SRC, 2: source operands per instruction (2 or 3).
- NUM_REGS, 32: architectural registers; x0 is hardwired zero.
- REG_AW, 5: register index width, $clog2(NUM_REGS).
- MAX_OUTSTANDING, 4: max in-flight long ops; counter width is $clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- RsD  in  NUM_SRC*REG_AW  D-stage source indices, slot i at [i*REG_AW +: REG_AW]
- RdD  in  REG_AW  D-stage destination
- RegWriteD  in  1  D instruction writes RdD
- LongOpD  in  1  D instruction is a long op
- RsE  in  NUM_SRC*REG_AW  E-stage source indices
- RdE, RdM, RdW  in  REG_AW  destinations in E/M/W
- PCSrcE  in  1  taken branch/jump resolved in E
- ResultSrcEb0  in  1  E instruction is a load
- RegWriteM, RegWriteW  in  1  writeback enables
- LongIssueE  in  1  long op in E is dispatched to the long unit this cycle
- CmplValid  in  1  long unit retires a result this cycle
- CmplRd  in  REG_AW  destination of the retiring long op
- StallF, StallD, FlushD, FlushE  out  1  pipeline control
- ForwardE  out  NUM_SRC*2  per-slot mux select: 00 RF, 10 M, 01 W
- BusyRegs  out  NUM_REGS  scoreboard, bit r = r pending
- OutstandingCnt  out  $clog2(MAX_OUTSTANDING+1)  in-flight long ops

Behaviour:
- **Reset** (rst_n low, async): BusyRegs=0, OutstandingCnt=0, perf counters=0. All other outputs are combinational. With no long-op traffic the block matches the legacy hazard unit exactly.
- **Forwarding**, per slot i:
  - If RsE[i]==0: select 00.
  - Else if RsE[i]==RdM & RegWriteM: select 10.
  - Else if RsE[i]==RdW & RegWriteW: select 01.
  - Else: select 00.
  - M has priority over W.
- **lwStall**: ResultSrcEb0 & (any slot RsD[i]==RdE), x0 included (legacy-conservative).
- **sbStall**, set when any of these holds:
  - RAW: BusyRegs[RsD[i]] for any i with RsD[i]!=0.
  - WAW: RegWriteD & RdD!=0 & BusyRegs[RdD].
  - Structural: LongOpD & OutstandingCnt==MAX_OUTSTANDING.
- **Pipeline control**:
  - StallF = StallD = lwStall | sbStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | sbStall | PCSrcE.
- **Scoreboard update** (posedge):
  - Issue: LongIssueE & RdE!=0 sets bit RdE.
  - Completion: CmplValid clears bit CmplRd.
  - Issue and completion to the same register in one cycle: set wins.
  - Bit 0 is never set.
- **Latency**: a cleared bit releases the stall on the cycle after CmplValid. No completion-to-D bypass; the RF is written by the long unit on the completion edge.
- **Counter**:
  - Issue only: +1. Completion only: -1. Both: unchanged.
  - Issue at MAX_OUTSTANDING holds the counter; the SVA flags it.
  - Completion at 0 holds 0; the SVA flags it.
- **PCSrcE during issue**: LongIssueE is still honoured, because the issuing op is older than the branch's victims.
- **Mid-operation reset**: clears all pending state immediately. The long unit is reset by the same rst_n.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds 32-bit saturating counters with output ports.
  - PerfLwStall: counts cycles with lwStall.
  - PerfSbStall: counts cycles with sbStall & !lwStall.
  - PerfFlush: counts cycles with PCSrcE.
  - All reset to 0.
- Undefined: the counters and their ports are absent. Functional behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - Forward-select enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
  - Default REG_AW / NUM_REGS localparams.
- One sub-module, hazard_sb_regs, holds the busy bit-vector, outstanding counter, set/clear priority and the SVA.
- Forwarding and stall logic stay in the top.

Test Plan:
- **Forward priority**: RsE slot0=5, RdM=5/RegWriteM=1, RdW=5/RegWriteW=1 -> ForwardE[1:0]=10. Drop RegWriteM -> 01. RsE=0 -> 00.
- **Load-use**: ResultSrcEb0=1, RdE=7, RsD slot1=7 -> StallF=StallD=FlushE=1 for exactly that cycle. RdE=8 -> all 0.
- **Long RAW**:
  - LongIssueE, RdE=9 -> BusyRegs[9]=1 next cycle.
  - RsD slot0=9 stalls until CmplValid/CmplRd=9; the stall drops one cycle after completion.
- **Same-cycle set/clear**: BusyRegs[4]=1, CmplValid/CmplRd=4 with LongIssueE/RdE=4 -> bit stays 1, counter unchanged.
- **Structural**: four issues to x1..x4, LongOpD=1 -> stall. One completion -> stall releases next cycle, counter 3.
- **Reset and x0**:
  - LongIssueE with RdE=0 -> no busy bit, counter +1.
  - Assert rst_n low mid-flight -> BusyRegs=0, OutstandingCnt=0 asynchronously.
